vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter CLK_DIV, 4, clk cycles per pixel (100 MHz clk -> 25 MHz pixel rate); legal range 1..16.
REQ-002 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-003 Parameters H_FP, H_PW, H_BP, 16/96/48, horizontal front porch, sync width and back porch in pixels.
REQ-004 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-005 Parameters V_FP, V_PW, V_BP, 10/2/33, vertical front porch, sync width and back porch in lines.
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 p_tick  output  1  one-clk pulse marking each pixel period.
REQ-009 pixel_x  output  10  current column, 0..H_TOTAL-1.
REQ-010 pixel_y  output  10  current line, 0..V_TOTAL-1.
REQ-011 video_on  output  1  high when the current pixel is visible.
REQ-012 hsync  output  1  horizontal sync, active-low.
REQ-013 vsync  output  1  vertical sync, active-low.
REQ-014 frame_start  output  1  one-clk pulse at start of frame; exists only with VGA_SYNC_FRAME_TICK_EN.

Function
REQ-015 H_TOTAL SHALL equal H_DISPLAY+H_FP+H_PW+H_BP (800); V_TOTAL SHALL equal V_DISPLAY+V_FP+V_PW+V_BP (525).
REQ-016 A divider counter SHALL count 0..CLK_DIV-1 and wrap; p_tick SHALL be high exactly in the cycle where the divider equals CLK_DIV-1.
REQ-017 pixel_x SHALL increment by 1 at the end of each p_tick cycle and wrap from H_TOTAL-1 to 0.
REQ-018 pixel_y SHALL increment only at the p_tick on which pixel_x wraps; it SHALL wrap from V_TOTAL-1 to 0 at the same edge.
REQ-019 pixel_x and pixel_y SHALL hold their values in every non-p_tick cycle.
REQ-020 hsync, vsync and video_on SHALL be registered and consistent with the pixel_x/pixel_y values of the same cycle (zero relative latency).
REQ-021 hsync SHALL be 0 iff H_DISPLAY+H_FP <= pixel_x <= H_DISPLAY+H_FP+H_PW-1 (656..751).
REQ-022 vsync SHALL be 0 iff V_DISPLAY+V_FP <= pixel_y <= V_DISPLAY+V_FP+V_PW-1 (490..491).
REQ-023 video_on SHALL be 1 iff pixel_x < H_DISPLAY and pixel_y < V_DISPLAY.
REQ-024 With CLK_DIV=1, p_tick SHALL be high in every cycle.

Reset
REQ-025 In the cycle after any clk edge with reset=1: divider=0, pixel_x=0, pixel_y=0, p_tick=0, hsync=1, vsync=1, video_on=1, frame_start=0.
REQ-026 Reset asserted mid-line or mid-frame SHALL abort the frame with no partial sync pulse held; counting restarts from (0,0).
REQ-027 After reset is deasserted, the first p_tick SHALL occur CLK_DIV cycles later.

Configuration
REQ-028 Macro VGA_SYNC_FRAME_TICK_EN defined: frame_start port present, high for exactly one clk in the p_tick cycle where pixel_x=H_TOTAL-1 and pixel_y=V_TOTAL-1.
REQ-029 Macro undefined: frame_start port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Timing defaults, H_TOTAL/V_TOTAL derivations and the 10-bit coordinate width SHALL live in shared package vga_timing_pkg, which the text and graphics generators also use.
REQ-031 The pixel-tick divider SHALL be a sub-module vga_tick_div (parameter CLK_DIV; ports clk, reset, tick).

Verification
REQ-032 Release reset with CLK_DIV=4 -> p_tick high on clk cycles 4, 8, 12...; pixel_x 0->1 after the first p_tick.
REQ-033 Run to pixel_x=799, pixel_y=10 -> next p_tick gives pixel_x=0, pixel_y=11; pixel_y unchanged at every other tick.
REQ-034 Scan one full line -> hsync low for exactly 96 ticks (656..751); scan a full frame -> vsync low for exactly 2 lines (490, 491).
REQ-035 Check (639,479) -> video_on=1; (640,0) -> 0; (0,480) -> 0; (799,524) -> 0.
REQ-036 Run a full frame -> wrap (799,524)->(0,0) after 420000 ticks = 1,680,000 clk; frame_start single pulse per frame when macro defined.
REQ-037 Assert reset at pixel_x=700 (hsync=0) -> next cycle hsync=1, counters (0,0), p_tick=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, total derivations and coordinate type.
// Also used by the text and graphics generators.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned DEF_CLK_DIV   = 4;
  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_PW      = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_PW      = 2;
  localparam int unsigned DEF_V_BP      = 33;

  function automatic int unsigned scan_total(input int unsigned disp, input int unsigned fp,
                                             input int unsigned pw, input int unsigned bp);
    return disp + fp + pw + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    scan_total(DEF_H_DISPLAY, DEF_H_FP, DEF_H_PW, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL =
    scan_total(DEF_V_DISPLAY, DEF_V_FP, DEF_V_PW, DEF_V_BP);

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-tick divider: one-cycle tick every CLK_DIV clocks (CLK_DIV in 1..16).
// The first tick lands CLK_DIV cycles after reset is released.
module vga_tick_div
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            run_q, run_d;

  // run_q holds the divider at 0 for one cycle after reset so tick spacing from release
  // equals CLK_DIV, including CLK_DIV=1 where the divider never leaves 0.
  always_comb begin
    run_d = 1'b1;
    div_d = div_q;
    if (run_q) begin
      div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
    end
    tick = run_q && (div_q == DivLast);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      run_q <= 1'b0;
    end else begin
      div_q <= div_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counter with registered, zero-latency hsync/vsync/video_on.
// Optional frame_start pulse enabled by defining VGA_SYNC_FRAME_TICK_EN.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_PW      = DEF_H_PW,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_PW      = DEF_V_PW,
  parameter int unsigned V_BP      = DEF_V_BP
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync
`ifdef VGA_SYNC_FRAME_TICK_EN
  ,
  output logic               frame_start
`endif
);

  localparam int unsigned H_TOTAL = scan_total(H_DISPLAY, H_FP, H_PW, H_BP);
  localparam int unsigned V_TOTAL = scan_total(V_DISPLAY, V_FP, V_PW, V_BP);

  localparam coord_t HLast   = COORD_W'(H_TOTAL - 1);
  localparam coord_t VLast   = COORD_W'(V_TOTAL - 1);
  localparam coord_t HDisp   = COORD_W'(H_DISPLAY);
  localparam coord_t VDisp   = COORD_W'(V_DISPLAY);
  localparam coord_t HsStart = COORD_W'(H_DISPLAY + H_FP);
  localparam coord_t HsEnd   = COORD_W'(H_DISPLAY + H_FP + H_PW - 1);
  localparam coord_t VsStart = COORD_W'(V_DISPLAY + V_FP);
  localparam coord_t VsEnd   = COORD_W'(V_DISPLAY + V_FP + V_PW - 1);

  coord_t x_q, x_d, y_q, y_d;
  logic   hs_q, hs_d, vs_q, vs_d, vid_q, vid_d;

  vga_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .tick (p_tick)
  );

  // Sync/blank flags are decoded from the next coordinates so the registered
  // outputs line up with pixel_x/pixel_y in the same cycle.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (p_tick) begin
      if (x_q == HLast) begin
        x_d = '0;
        y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    hs_d  = !((x_d >= HsStart) && (x_d <= HsEnd));
    vs_d  = !((y_d >= VsStart) && (y_d <= VsEnd));
    vid_d = (x_d < HDisp) && (y_d < VDisp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      vid_q <= 1'b1;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vid_q <= vid_d;
    end
  end

  assign pixel_x  = x_q;
  assign pixel_y  = y_q;
  assign hsync    = hs_q;
  assign vsync    = vs_q;
  assign video_on = vid_q;

`ifdef VGA_SYNC_FRAME_TICK_EN
  assign frame_start = p_tick && (x_q == HLast) && (y_q == VLast);
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: default 640x480 timing at CLK_DIV=4 plus a tiny raster at CLK_DIV=1.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_tick, a_vid, a_hs, a_vs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_vid, b_hs, b_vs;
  logic [9:0] b_x, b_y;
`ifdef VGA_SYNC_FRAME_TICK_EN
  logic       a_fs, b_fs;
`endif

  vga_sync_gen #(
    .CLK_DIV(4)
  ) dut_a (
    .clk     (clk),
    .reset   (reset),
    .p_tick  (a_tick),
    .pixel_x (a_x),
    .pixel_y (a_y),
    .video_on(a_vid),
    .hsync   (a_hs),
    .vsync   (a_vs)
`ifdef VGA_SYNC_FRAME_TICK_EN
    ,
    .frame_start(a_fs)
`endif
  );

  // 15 x 10 raster: hsync 10..12, vsync lines 7..8, visible 8 x 6.
  vga_sync_gen #(
    .CLK_DIV  (1),
    .H_DISPLAY(8),
    .H_FP     (2),
    .H_PW     (3),
    .H_BP     (2),
    .V_DISPLAY(6),
    .V_FP     (1),
    .V_PW     (2),
    .V_BP     (1)
  ) dut_b (
    .clk     (clk),
    .reset   (reset),
    .p_tick  (b_tick),
    .pixel_x (b_x),
    .pixel_y (b_y),
    .video_on(b_vid),
    .hsync   (b_hs),
    .vsync   (b_vs)
`ifdef VGA_SYNC_FRAME_TICK_EN
    ,
    .frame_start(b_fs)
`endif
  );

  typedef struct {
    int unsigned cyc;
    int unsigned x;
    int unsigned y;
    logic        hs;
    logic        vs;
    logic        vid;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  int unsigned prev_x, ticks, hs_low, y_moved, x_glitch, first_tick, vi;
  int unsigned c, ex, ey, vs_lines, fs_count;
  logic        prev_tick;

  initial begin
    // {cycle after release, x, y, hsync, vsync, video_on}; tick k ends in cycle 4k.
    vecs[0]  = '{5,     1,   0,  1'b1, 1'b1, 1'b1};
    vecs[1]  = '{2557,  639, 0,  1'b1, 1'b1, 1'b1};
    vecs[2]  = '{2561,  640, 0,  1'b1, 1'b1, 1'b0};
    vecs[3]  = '{2621,  655, 0,  1'b1, 1'b1, 1'b0};
    vecs[4]  = '{2625,  656, 0,  1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3005,  751, 0,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3009,  752, 0,  1'b1, 1'b1, 1'b0};
    vecs[7]  = '{3197,  799, 0,  1'b1, 1'b1, 1'b0};
    vecs[8]  = '{3201,  0,   1,  1'b1, 1'b1, 1'b1};
    vecs[9]  = '{35197, 799, 10, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{35201, 0,   11, 1'b1, 1'b1, 1'b1};

    apply_reset();
    check("rst_x", a_x, 0);
    check("rst_y", a_y, 0);
    check("rst_tick", a_tick, 0);
    check("rst_hsync", a_hs, 1);
    check("rst_vsync", a_vs, 1);
    check("rst_video_on", a_vid, 1);
    check("rst_tick_div1", b_tick, 0);
`ifdef VGA_SYNC_FRAME_TICK_EN
    check("rst_frame_start", a_fs, 0);
`endif

    prev_x = 0;
    prev_tick = 1'b0;
    ticks = 0;
    hs_low = 0;
    y_moved = 0;
    x_glitch = 0;
    first_tick = 0;
    vi = 0;
    while (vi < NVEC) begin
      next_cycle();
      if (cyc <= 12) check("tick_phase", a_tick, (cyc % 4) == 0);
      if (cyc <= 3200) begin
        if (!prev_tick && (a_x != prev_x)) x_glitch++;
        if (a_tick) begin
          ticks++;
          if (first_tick == 0) first_tick = cyc;
          if (!a_hs) hs_low++;
          if (a_y != 0) y_moved++;
        end
      end
      if (cyc == 3200) begin
        check("line_ticks", ticks, 800);
        check("first_tick_cycle", first_tick, 4);
        check("hsync_low_ticks", hs_low, 96);
        check("y_hold_in_line", y_moved, 0);
        check("x_hold_no_tick", x_glitch, 0);
      end
      prev_x = a_x;
      prev_tick = a_tick;
      if (cyc == vecs[vi].cyc) begin
        check($sformatf("vec%0d_x", vi), a_x, vecs[vi].x);
        check($sformatf("vec%0d_y", vi), a_y, vecs[vi].y);
        check($sformatf("vec%0d_hsync", vi), a_hs, vecs[vi].hs);
        check($sformatf("vec%0d_vsync", vi), a_vs, vecs[vi].vs);
        check($sformatf("vec%0d_video_on", vi), a_vid, vecs[vi].vid);
        vi++;
      end
    end

    // Reset in the middle of the hsync pulse.
    apply_reset();
    while (cyc < 2801) next_cycle();
    check("mid_x", a_x, 700);
    check("mid_hsync", a_hs, 0);
    reset = 1'b1;
    next_cycle();
    check("abort_hsync", a_hs, 1);
    check("abort_x", a_x, 0);
    check("abort_y", a_y, 0);
    check("abort_tick", a_tick, 0);
    check("abort_video_on", a_vid, 1);
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      check("rerelease_tick", a_tick, cyc == 4);
    end

    // Two full frames of the small raster against a coordinate model.
    apply_reset();
    check("b_rst_x", b_x, 0);
    check("b_rst_tick", b_tick, 0);
    vs_lines = 0;
    fs_count = 0;
    for (int n = 0; n < 300; n++) begin
      next_cycle();
      c  = (cyc - 1) % 150;
      ex = c % 15;
      ey = c / 15;
      check("b_tick", b_tick, 1);
      check("b_x", b_x, ex);
      check("b_y", b_y, ey);
      check("b_hsync", b_hs, !(ex >= 10 && ex <= 12));
      check("b_vsync", b_vs, !(ey >= 7 && ey <= 8));
      check("b_video_on", b_vid, (ex < 8) && (ey < 6));
      if (ex == 0 && !b_vs) vs_lines++;
`ifdef VGA_SYNC_FRAME_TICK_EN
      check("b_frame_start", b_fs, (ex == 14) && (ey == 9));
      if (b_fs) fs_count++;
`endif
    end
    check("b_vsync_lines", vs_lines, 4);
`ifdef VGA_SYNC_FRAME_TICK_EN
    check("b_frame_starts", fs_count, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
